// File: rtl/l2c_txn_sequencer_pkg.sv
// l2c_txn_sequencer_pkg: L2CPKG types and sizes shared by the L2 transaction sequencer and its LRU helper.
package L2CPKG;
  localparam int PA_BITS    = 32;
  localparam int L2_ASSOC   = 4;
  localparam int L2_LINE_SZ = 8;
  localparam int OFFSET_LEN = $clog2(L2_LINE_SZ);
  localparam int INDEX_LEN  = 4;
  localparam int TAG_LEN    = PA_BITS - INDEX_LEN - OFFSET_LEN;
  localparam int RU_LEN     = $clog2(L2_ASSOC);
  typedef enum logic [1:0] {INV, SHRD, EXCL, MOD} MESI_STATES;
  typedef enum logic [1:0] {READ, WRITE, INVALIDATE, RWIM} BUS_OP;
  typedef enum logic [1:0] {NOTHIT, HIT, HITM} SNOOP_RESP;
  typedef logic [TAG_LEN-1:0] TYP_TAG;
  typedef logic [RU_LEN-1:0] TYP_RU_NUM;
  typedef struct packed {
    MESI_STATES             mesi;
    TYP_RU_NUM              ru_num;
    TYP_TAG                 tag;
    logic [INDEX_LEN-1:0]   indx;
    logic [L2_LINE_SZ*8-1:0] data;
  } CLINE;
  typedef CLINE [L2_ASSOC-1:0] CSET;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, INVAL, UPDATE} TXN_STATE;
endpackage

// File: rtl/l2c_lru_update.sv
// l2c_lru_update: recency update for one set; accessed way becomes 0, younger valid ways age by one.
module l2c_lru_update
  import L2CPKG::*;
#(
  parameter int L2_ASSOC = L2CPKG::L2_ASSOC
) (
  input  CSET                            set_i,
  input  logic [$clog2(L2_ASSOC)-1:0]    way_i,
  output TYP_RU_NUM [L2_ASSOC-1:0]       ru_o
);
  localparam int WL = $clog2(L2_ASSOC);
  TYP_RU_NUM old;
  always_comb begin
    old = set_i[way_i].mesi == INV ? TYP_RU_NUM'(L2_ASSOC-1) : set_i[way_i].ru_num;
    for (int w = 0; w < L2_ASSOC; w++)
      ru_o[w] = WL'(w) == way_i ? '0 :
                (set_i[w].mesi != INV && set_i[w].ru_num < old) ? set_i[w].ru_num + 1'b1 :
                set_i[w].ru_num;
  end
endmodule

// File: rtl/l2c_txn_sequencer.sv
// l2c_txn_sequencer: one-at-a-time L2 lookup, victim writeback/fill, upgrade and MESI/LRU set update.
module l2c_txn_sequencer
  import L2CPKG::*;
#(
  parameter int PA_BITS  = L2CPKG::PA_BITS,
  parameter int L2_ASSOC = L2CPKG::L2_ASSOC,
  parameter int LINE_SZ  = L2CPKG::L2_LINE_SZ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [PA_BITS-1:0]   req_addr,
  output logic                 set_rd_en,
  output logic [INDEX_LEN-1:0] set_idx,
  input  CSET                  set_rd_data,
  output logic                 set_wr_en,
  output CSET                  set_wr_data,
  output logic                 bus_req,
  output BUS_OP                bus_op,
  output logic [PA_BITS-1:0]   bus_addr,
  input  logic                 bus_done,
  input  SNOOP_RESP            snoop_resp,
  output logic                 resp_valid,
  output logic                 resp_hit
);
  localparam int OFF = $clog2(LINE_SZ);
  localparam int WL  = $clog2(L2_ASSOC);
  TXN_STATE state_q, state_d;
  logic wr_q, hit_q;
  TYP_TAG tag_q;
  logic [INDEX_LEN-1:0] idx_q;
  CSET set_q, nset;
  logic [WL-1:0] way_q, hit_way, inv_way, lru_way, vic_way, acc_way;
  SNOOP_RESP snoop_q;
  logic hit, inv_found;
  TYP_RU_NUM [L2_ASSOC-1:0] ru_new;
  logic unused_off;
  assign unused_off = ^req_addr[OFF-1:0];
  // Descending scan so the lowest-numbered matching way wins.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv_found = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = L2_ASSOC-1; w >= 0; w--) begin
      if (set_rd_data[w].mesi != INV && set_rd_data[w].tag == tag_q) begin
        hit = 1'b1;
        hit_way = WL'(w);
      end
      if (set_rd_data[w].mesi == INV) begin
        inv_found = 1'b1;
        inv_way = WL'(w);
      end
      if (set_rd_data[w].ru_num == TYP_RU_NUM'(L2_ASSOC-1)) lru_way = WL'(w);
    end
  end
  assign vic_way = inv_found ? inv_way : lru_way;
  assign acc_way = hit ? hit_way : vic_way;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (req_valid) state_d = LOOKUP;
      LOOKUP:      state_d = hit ? ((wr_q && set_rd_data[hit_way].mesi == SHRD) ? INVAL : UPDATE)
                                 : (set_rd_data[vic_way].mesi == MOD ? WB : FILL);
      WB:          if (bus_done) state_d = FILL;
      FILL, INVAL: if (bus_done) state_d = UPDATE;
      UPDATE:      state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q <= 1'b0;
      hit_q <= 1'b0;
      tag_q <= '0;
      idx_q <= '0;
      set_q <= '0;
      way_q <= '0;
      snoop_q <= NOTHIT;
    end else begin
      state_q <= state_d;
      if (set_rd_en) begin
        wr_q <= req_wr;
        tag_q <= req_addr[PA_BITS-1 -: TAG_LEN];
        idx_q <= req_addr[OFF +: INDEX_LEN];
      end
      if (state_q == LOOKUP) begin
        set_q <= set_rd_data;
        way_q <= acc_way;
        hit_q <= hit;
      end
      if (state_q == FILL && bus_done) snoop_q <= snoop_resp;
    end
  end
  l2c_lru_update #(.L2_ASSOC(L2_ASSOC)) u_lru (
    .set_i(set_q),
    .way_i(way_q),
    .ru_o (ru_new)
  );
  // Data bytes pass through untouched; only state, recency and (on fill) tag/index change.
  always_comb begin
    nset = set_q;
    for (int w = 0; w < L2_ASSOC; w++) nset[w].ru_num = ru_new[w];
    nset[way_q].mesi = wr_q ? MOD : hit_q ? set_q[way_q].mesi : (snoop_q == NOTHIT ? EXCL : SHRD);
    if (!hit_q) begin
      nset[way_q].tag = tag_q;
      nset[way_q].indx = idx_q;
    end
  end
  assign req_ready   = state_q == IDLE;
  assign set_rd_en   = req_ready && req_valid;
  assign set_idx     = set_rd_en ? req_addr[OFF +: INDEX_LEN] : idx_q;
  assign bus_req     = state_q == WB || state_q == FILL || state_q == INVAL;
  assign bus_op      = state_q == WB ? WRITE : state_q == FILL ? (wr_q ? RWIM : READ) :
                       state_q == INVAL ? INVALIDATE : READ;
  assign bus_addr    = bus_req ? {state_q == WB ? set_q[way_q].tag : tag_q, idx_q, OFF'(0)} : '0;
  assign set_wr_en   = state_q == UPDATE;
  assign set_wr_data = set_wr_en ? nset : '0;
  assign resp_valid  = set_wr_en;
  assign resp_hit    = set_wr_en && hit_q;
endmodule

// File: tb/tb_l2c_txn_sequencer.sv
// tb_l2c_txn_sequencer: directed and random transactions scored against a set-level reference model.
module tb_l2c_txn_sequencer;
  import L2CPKG::*;
  localparam int OFF = OFFSET_LEN;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [PA_BITS-1:0] req_addr = '0, bus_addr;
  logic set_rd_en, set_wr_en, bus_req, bus_done = 1'b0, resp_valid, resp_hit;
  logic [INDEX_LEN-1:0] set_idx;
  CSET set_rd_data = '0, set_wr_data;
  BUS_OP bus_op;
  SNOOP_RESP snoop_resp = NOTHIT;
  CSET mem [1<<INDEX_LEN];
  int n_vec = 0, n_err = 0;
  l2c_txn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .set_rd_en(set_rd_en), .set_idx(set_idx), .set_rd_data(set_rd_data),
    .set_wr_en(set_wr_en), .set_wr_data(set_wr_data), .bus_req(bus_req), .bus_op(bus_op),
    .bus_addr(bus_addr), .bus_done(bus_done), .snoop_resp(snoop_resp), .resp_valid(resp_valid),
    .resp_hit(resp_hit)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (set_rd_en) set_rd_data <= mem[set_idx];
  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [PA_BITS-1:0] mk_addr(input TYP_TAG t, input logic [INDEX_LEN-1:0] i);
    return {t, i, {OFF{1'b0}}};
  endfunction
  task automatic set_line(input int i, input int w, input MESI_STATES m, input int ru, input int t);
    mem[i][w].mesi = m;
    mem[i][w].ru_num = TYP_RU_NUM'(ru);
    mem[i][w].tag = TYP_TAG'(t);
    mem[i][w].indx = INDEX_LEN'(i);
  endtask
  task automatic run_txn(input logic wr, input int t, input int i, input SNOOP_RESP sn);
    CSET s, e;
    TYP_TAG tag;
    logic [INDEX_LEN-1:0] idx;
    int way, nops, old, lat, cyc, opi, wc;
    bit hit, done;
    BUS_OP eop [2];
    logic [PA_BITS-1:0] ead [2];
    int dly [2];
    tag = TYP_TAG'(t);
    idx = INDEX_LEN'(i);
    s = mem[i];
    hit = 0;
    way = -1;
    for (int w = 0; w < L2_ASSOC; w++)
      if (!hit && s[w].mesi != INV && s[w].tag == tag) begin hit = 1; way = w; end
    if (!hit) begin
      for (int w = 0; w < L2_ASSOC; w++) if (way < 0 && s[w].mesi == INV) way = w;
      for (int w = 0; w < L2_ASSOC; w++) if (way < 0 && int'(s[w].ru_num) == L2_ASSOC-1) way = w;
      if (way < 0) way = 0;
    end
    nops = 0;
    if (hit && wr && s[way].mesi == SHRD) begin eop[0] = INVALIDATE; ead[0] = mk_addr(tag, idx); nops = 1; end
    if (!hit) begin
      if (s[way].mesi == MOD) begin eop[nops] = WRITE; ead[nops] = mk_addr(s[way].tag, idx); nops++; end
      eop[nops] = wr ? RWIM : READ;
      ead[nops] = mk_addr(tag, idx);
      nops++;
    end
    e = s;
    old = s[way].mesi == INV ? L2_ASSOC-1 : int'(s[way].ru_num);
    for (int w = 0; w < L2_ASSOC; w++)
      if (w == way) e[w].ru_num = '0;
      else if (s[w].mesi != INV && int'(s[w].ru_num) < old) e[w].ru_num = TYP_RU_NUM'(int'(s[w].ru_num) + 1);
    e[way].mesi = wr ? MOD : hit ? s[way].mesi : (sn == NOTHIT ? EXCL : SHRD);
    if (!hit) begin e[way].tag = tag; e[way].indx = idx; end
    lat = 2;
    for (int k = 0; k < nops; k++) begin dly[k] = $urandom_range(0, 2); lat += dly[k] + 1; end
    @(negedge clk);
    check("ready", req_ready, 1);
    req_valid = 1'b1;
    req_wr = wr;
    req_addr = mk_addr(tag, idx) | PA_BITS'($urandom_range(0, L2_LINE_SZ-1));
    #1;
    check("rd_en", set_rd_en, 1);
    check("rd_idx", set_idx, idx);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; opi = 0; wc = 0; done = 0;
    while (!done && cyc < 100) begin
      bus_done = 1'b0;
      if (resp_valid) begin
        check("latency", cyc, lat);
        check("bus_ops", opi, nops);
        check("resp_hit", resp_hit, hit);
        check("wr_en", set_wr_en, 1);
        check("wr_idx", set_idx, idx);
        check("wr_data", set_wr_data, e);
        mem[i] = e;
        done = 1;
      end else if (bus_req) begin
        if (wc == 0) begin
          if (opi < nops) begin
            check("bus_op", bus_op, eop[opi]);
            check("bus_addr", bus_addr, ead[opi]);
          end else check("extra_op", opi, nops);
        end
        if (opi >= nops || wc == dly[opi]) begin
          bus_done = 1'b1;
          snoop_resp = (opi < nops && eop[opi] == WRITE) ? SNOOP_RESP'($urandom_range(0, 2)) : sn;
          opi++;
          wc = 0;
        end else wc++;
      end
      if (!done) begin @(negedge clk); cyc++; end
    end
    bus_done = 1'b0;
    if (!done) check("timeout", cyc, lat);
  endtask
  initial begin
    int spin;
    for (int i = 0; i < (1<<INDEX_LEN); i++)
      for (int w = 0; w < L2_ASSOC; w++) begin
        mem[i][w].mesi = INV;
        mem[i][w].ru_num = TYP_RU_NUM'(w);
        mem[i][w].tag = TYP_TAG'($urandom);
        mem[i][w].indx = '0;
        mem[i][w].data = {$urandom, $urandom};
      end
    for (int w = 0; w < L2_ASSOC; w++) set_line(2, w, w[0] ? SHRD : EXCL, (w == 0) ? 3 : (w == 1) ? 1 : (w == 2) ? 0 : 2, 10 + w);
    set_line(3, 0, EXCL, 0, 21);
    set_line(3, 1, SHRD, 1, 20);
    for (int w = 0; w < L2_ASSOC; w++) set_line(4, w, w == 3 ? MOD : EXCL, w, 30 + w);
    #12;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_op", bus_op, READ);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_rd_en", set_rd_en, 0);
    check("rst_wr_en", set_wr_en, 0);
    check("rst_wr_data", set_wr_data, 0);
    check("rst_resp", {resp_valid, resp_hit}, 0);
    check("rst_idx", set_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 7, 1, NOTHIT);
    run_txn(1'b0, 12, 2, NOTHIT);
    run_txn(1'b1, 20, 3, NOTHIT);
    run_txn(1'b1, 40, 4, HIT);
    run_txn(1'b0, 50, 6, HITM);
    @(negedge clk);
    bus_done = 1'b1;
    snoop_resp = HITM;
    @(negedge clk);
    bus_done = 1'b0;
    check("idle_done_bus", bus_req, 0);
    check("idle_done_resp", resp_valid, 0);
    check("idle_done_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr = 1'b0;
    req_addr = mk_addr(TYP_TAG'(60), INDEX_LEN'(5));
    @(negedge clk);
    req_valid = 1'b0;
    spin = 0;
    while (!bus_req && spin < 10) begin @(negedge clk); spin++; end
    check("fill_reached", bus_req, 1);
    rst_n = 1'b0;
    #1;
    check("abort_bus_req", bus_req, 0);
    check("abort_wr_en", set_wr_en, 0);
    check("abort_resp", resp_valid, 0);
    check("abort_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 60, 5, HIT);
    for (int n = 0; n < 150; n++)
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 3), SNOOP_RESP'($urandom_range(0, 2)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
